// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, parser state/error encodings and header constants for the ALU command parser
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'hAD;
    localparam logic [7:0] OP_MUL = 8'h88;
    localparam logic [7:0] OP_DIV = 8'hD1;

    localparam int HDR_BYTES = 4;
    localparam int MIN_LEN   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OPCODE,
        ERR_LEN,
        ERR_TIMEOUT
    } err_code_t;

    function automatic logic op_valid(input logic [7:0] op);
        return op == OP_ADD || op == OP_MUL || op == OP_DIV;
    endfunction

endpackage

// File: rtl/alu_cmd_parser_byte_to_word.sv
// byte_to_word: packs payload bytes LSB-first into a word and holds it until the ALU accepts it
module byte_to_word #(
    parameter int DATA_WIDTH_P = 8,
    parameter int WORD_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] in_data,
    input  logic                    in_fire,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic                    clear_i,
    output logic [WORD_WIDTH_P-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_first,
    output logic                    m_last,
    output logic                    word_done_o
);

    logic [1:0]              idx_q;
    logic [WORD_WIDTH_P-1:0] sr_q;

    assign word_done_o = in_fire && idx_q == 2'd3;

    // Shift bytes in from the top so the 4th byte completes a little-endian word; load wins over accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= '0;
            sr_q     <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_first  <= 1'b0;
            m_last   <= 1'b0;
        end else if (clear_i) begin
            idx_q    <= '0;
            sr_q     <= '0;
            m_tvalid <= 1'b0;
        end else begin
            if (in_fire) begin
                idx_q <= idx_q + 2'd1;
                sr_q  <= {in_data, sr_q[WORD_WIDTH_P-1:DATA_WIDTH_P]};
            end
            if (word_done_o) begin
                m_tdata  <= {in_data, sr_q[WORD_WIDTH_P-1:DATA_WIDTH_P]};
                m_tvalid <= 1'b1;
                m_first  <= first_i;
                m_last   <= last_i;
            end else if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: parses ALU command packets from the UART byte stream into operands (inter-byte timeout with ALU_PARSER_TIMEOUT_EN)
module alu_cmd_parser
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P     = 8,
    parameter int WORD_WIDTH_P     = 32,
    parameter int TIMEOUT_CYCLES_P = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [WORD_WIDTH_P-1:0] m_op_tdata,
    output logic                    m_op_tvalid,
    input  logic                    m_op_tready,
    output logic                    m_op_first,
    output logic                    m_op_last,
    output logic [7:0]              opcode_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o
);

    state_t    state_q, state_d;
    err_code_t err_code_q;
    logic [7:0]  opcode_q, len_lo_q;
    logic [15:0] rem_q, len_w;
    logic first_q, fire, in_fire, word_done, m_accept, bad_op, bad_len, tmo, last_wait;

    assign fire       = s_axis_tvalid && s_axis_tready;
    assign m_accept   = m_op_tvalid && m_op_tready;
    assign last_wait  = state_q == ST_PAYLOAD && rem_q == 16'd0;
    assign in_fire    = fire && state_q == ST_PAYLOAD && rem_q != 16'd0;
    assign len_w      = {s_axis_tdata[7:0], len_lo_q};
    assign bad_op     = !op_valid(opcode_q);
    assign bad_len    = len_w < 16'(MIN_LEN) || len_w[1:0] != 2'd0;
    assign opcode_o   = opcode_q;
    assign err_code_o = err_code_q;

`ifdef ALU_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);
    logic [TW-1:0] tmo_q;
    logic          tick;
    assign tick = state_q != ST_IDLE && !fire && !(m_op_tvalid && !m_op_tready);
    assign tmo  = tick && tmo_q == TW'(TIMEOUT_CYCLES_P - 1);
    // Count idle cycles mid-packet; a stalled ALU does not count against the sender
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= (fire || tmo || state_q == ST_IDLE) ? '0 : tick ? tmo_q + TW'(1) : tmo_q;
    end
`else
    assign tmo = TIMEOUT_CYCLES_P < 0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state; a trailing byte accepted while the last word leaves is the next opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (fire) state_d = ST_RSVD;
            ST_RSVD:    if (fire) state_d = ST_LEN_LO;
            ST_LEN_LO:  if (fire) state_d = ST_LEN_HI;
            ST_LEN_HI:  if (fire) state_d = !(bad_op || bad_len) ? ST_PAYLOAD :
                                            len_w <= 16'(HDR_BYTES) ? ST_IDLE : ST_DRAIN;
            ST_PAYLOAD: if (last_wait && m_accept) state_d = fire ? ST_RSVD : ST_IDLE;
            ST_DRAIN:   if (fire && rem_q == 16'd1) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (tmo) state_d = ST_IDLE;
    end

    // Byte acceptance is throttled only by the operand holding register
    always_comb begin
        s_axis_tready = state_q == ST_PAYLOAD ? (!m_op_tvalid || m_op_tready) : 1'b1;
    end

    // Header capture, remaining-byte count and error reporting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            err_o      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_o <= 1'b0;
            if (tmo) begin
                err_o      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                rem_q      <= '0;
            end else if (fire) begin
                if (state_q == ST_IDLE || last_wait) begin
                    opcode_q   <= s_axis_tdata[7:0];
                    err_code_q <= ERR_NONE;
                end
                if (state_q == ST_LEN_LO) len_lo_q <= s_axis_tdata[7:0];
                if (state_q == ST_LEN_HI) begin
                    rem_q      <= len_w <= 16'(HDR_BYTES) ? '0 : len_w - 16'(HDR_BYTES);
                    first_q    <= 1'b1;
                    err_o      <= bad_op || bad_len;
                    err_code_q <= bad_op ? ERR_OPCODE : bad_len ? ERR_LEN : ERR_NONE;
                end
                if (in_fire || state_q == ST_DRAIN) rem_q <= rem_q - 16'd1;
                if (word_done) first_q <= 1'b0;
            end
        end
    end

    byte_to_word #(
        .DATA_WIDTH_P(DATA_WIDTH_P),
        .WORD_WIDTH_P(WORD_WIDTH_P)
    ) u_b2w (
        .clk        (clk),
        .rst        (rst),
        .in_data    (s_axis_tdata),
        .in_fire    (in_fire),
        .first_i    (first_q),
        .last_i     (rem_q == 16'd1),
        .clear_i    (tmo),
        .m_tdata    (m_op_tdata),
        .m_tvalid   (m_op_tvalid),
        .m_tready   (m_op_tready),
        .m_first    (m_op_first),
        .m_last     (m_op_last),
        .word_done_o(word_done)
    );

endmodule
